redmule_tile_planner: RTL and testbench
=======================================

REDMULE_TILE_PLANNER -- requirements
Module: redmule_tile_planner

Interface
REQ-001 SHALL have parameter ARRAY_WIDTH, default 12, meaning the number of CE rows (X rows per tile).
REQ-002 SHALL have parameter ARRAY_HEIGHT, default 4, meaning the number of CE columns.
REQ-003 SHALL have parameter PIPE_REGS, default 3, meaning the CE pipeline depth; TILE = ARRAY_HEIGHT*(PIPE_REGS+1).
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port clear_i, input, 1 bit: synchronous abort to IDLE.
REQ-006 SHALL have ports start_i, input, 1 bit; m_size_i, n_size_i, k_size_i, input, 16 bits each; mx_en_i, input, 1 bit.
REQ-007 SHALL have ports busy_o, output, 1 bit; valid_o, output, 1 bit; ready_i, input, 1 bit; ovf_o, output, 1 bit.
REQ-008 SHALL have outputs x_rows_iter_o, x_cols_iter_o, w_rows_iter_o, w_cols_iter_o, tot_stores_o, 16 bits each.
REQ-009 SHALL have outputs x_rows_lftovr_o, x_cols_lftovr_o, w_rows_lftovr_o, w_cols_lftovr_o, 8 bits each.
REQ-010 SHALL have outputs w_tot_len_o, tot_x_read_o, z_tot_len_o, 32 bits each.

Function
REQ-011 SHALL sample the sizes into registers when start_i is high in IDLE (the accept cycle T); start_i SHALL be ignored in every other state.
REQ-012 SHALL implement the states IDLE -> CALC (1 cycle) -> MUL1 -> MUL2 -> MUL3 (16 cycles each) -> DONE.
REQ-013 In CALC it SHALL compute and register: x_rows = ceil(m/ARRAY_WIDTH); x_cols = ceil(n/TILE); w_cols = ceil(k/TILE); w_rows = n rounded up to a multiple of ARRAY_HEIGHT.
REQ-014 In CALC it SHALL also register the leftovers m mod ARRAY_WIDTH, n mod TILE, n mod ARRAY_HEIGHT and k mod TILE, each truncated to 8 bits.
REQ-015 SHALL use one shared 16x32 shift-add multiplier for all three products: MUL1 forms P1 = x_rows*w_cols; MUL2 forms x_cols*P1; MUL3 forms w_rows*P1.
REQ-016 Outputs: tot_stores = P1[15:0]; tot_x_read = MUL2 product[31:0]; w_tot_len = MUL3 product[31:0]; z_tot_len = ARRAY_WIDTH*P1[15:0], truncated to 32 bits.
REQ-017 ovf_o SHALL be set when P1 exceeds 16 bits or any 48-bit product has a nonzero bit in [47:32].
REQ-018 valid_o SHALL rise at cycle T+50 and hold, with all outputs stable, until the cycle in which ready_i is high; the FSM SHALL then return to IDLE.
REQ-019 valid_o and ready_i both high in the same cycle as start_i SHALL return the FSM to IDLE without accepting that start.
REQ-020 busy_o SHALL be high in every state except IDLE.
REQ-021 A size of zero SHALL yield zero iterations and zero products and SHALL still complete with valid_o.
REQ-022 clear_i SHALL force IDLE and zero all outputs on the next edge; clear_i has priority over start_i and ready_i.
REQ-023 Result outputs SHALL hold their last values in IDLE until the next CALC.

Reset
REQ-024 While rst_i is high, the FSM SHALL be in IDLE and every output and internal register SHALL be 0, independent of clk_i.
REQ-025 Asserting rst_i mid-computation SHALL abandon the operation; no valid_o SHALL follow after release without a new start.

Configuration
REQ-026 Macro REDMULE_TILE_PLANNER_MX_EN: when defined, a start accepted with mx_en_i=1 SHALL double z_tot_len (saturating-free truncation to 32 bits); when undefined, mx_en_i SHALL be ignored and z_tot_len SHALL be ARRAY_WIDTH*P1 only.

Verification
REQ-027 Defaults, m=24, n=32, k=32, start -> at T+50: x_rows=2, x_cols=2, w_cols=2, w_rows=32, tot_stores=4, tot_x_read=8, w_tot_len=128, z_tot_len=48, all leftovers 0.
REQ-028 m=13, n=17, k=20 -> leftovers x_rows=1, x_cols=1, w_rows=1, w_cols=4; w_rows_iter=20, tot_x_read=8, w_tot_len=80.
REQ-029 MX_EN defined, mx_en_i=1, m=24, n=32, k=32 -> z_tot_len=96; same stimulus with the macro undefined -> z_tot_len=48.
REQ-030 Hold ready_i=0 for 10 cycles after valid_o -> outputs stable and valid_o held; a start pulse during DONE is ignored.
REQ-031 clear_i at T+20 -> busy_o=0 and outputs 0 at T+21, no valid_o; rst_i pulse during MUL2 -> same result.
REQ-032 m=n=k=65535 -> ovf_o=1 and valid_o at T+50.

Source files
------------

// File: rtl/redmule_tile_planner_if.sv
`default_nettype none
// ============================================================================
// Module      : redmule_tile_planner_if
// Description : Command / result bundle between a controller and the RedMulE
//               tile planner.
// Revision    : 1.0 - initial release
// ============================================================================
interface redmule_tile_planner_if;
    logic        clear_i;
    logic        start_i;
    logic [15:0] m_size_i;
    logic [15:0] n_size_i;
    logic [15:0] k_size_i;
    logic        mx_en_i;
    logic        ready_i;
    logic        busy_o;
    logic        valid_o;
    logic        ovf_o;
    logic [15:0] x_rows_iter_o;
    logic [15:0] x_cols_iter_o;
    logic [15:0] w_rows_iter_o;
    logic [15:0] w_cols_iter_o;
    logic [15:0] tot_stores_o;
    logic [7:0]  x_rows_lftovr_o;
    logic [7:0]  x_cols_lftovr_o;
    logic [7:0]  w_rows_lftovr_o;
    logic [7:0]  w_cols_lftovr_o;
    logic [31:0] w_tot_len_o;
    logic [31:0] tot_x_read_o;
    logic [31:0] z_tot_len_o;

    modport master (
        output clear_i, start_i, m_size_i, n_size_i, k_size_i, mx_en_i, ready_i,
        input  busy_o, valid_o, ovf_o,
               x_rows_iter_o, x_cols_iter_o, w_rows_iter_o, w_cols_iter_o, tot_stores_o,
               x_rows_lftovr_o, x_cols_lftovr_o, w_rows_lftovr_o, w_cols_lftovr_o,
               w_tot_len_o, tot_x_read_o, z_tot_len_o
    );

    modport slave (
        input  clear_i, start_i, m_size_i, n_size_i, k_size_i, mx_en_i, ready_i,
        output busy_o, valid_o, ovf_o,
               x_rows_iter_o, x_cols_iter_o, w_rows_iter_o, w_cols_iter_o, tot_stores_o,
               x_rows_lftovr_o, x_cols_lftovr_o, w_rows_lftovr_o, w_cols_lftovr_o,
               w_tot_len_o, tot_x_read_o, z_tot_len_o
    );
endinterface
`default_nettype wire

// File: rtl/redmule_tile_planner.sv
`default_nettype none
// ============================================================================
// Module      : redmule_tile_planner
// Description : Turns GEMM sizes M/N/K into tile iteration counts, leftovers
//               and transfer lengths using one shared 16x32 shift-add
//               multiplier. Optional macro REDMULE_TILE_PLANNER_MX_EN doubles
//               z_tot_len for starts accepted with mx_en_i=1.
// Revision    : 1.0 - initial release
// ============================================================================
module redmule_tile_planner #(
    parameter int unsigned ARRAY_WIDTH  = 12,
    parameter int unsigned ARRAY_HEIGHT = 4,
    parameter int unsigned PIPE_REGS    = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    redmule_tile_planner_if.slave         bus
);
    localparam logic [15:0] c_aw   = 16'(ARRAY_WIDTH);
    localparam logic [15:0] c_ah   = 16'(ARRAY_HEIGHT);
    localparam logic [15:0] c_tile = 16'(ARRAY_HEIGHT * (PIPE_REGS + 1));
    localparam logic [31:0] c_aw32 = 32'(ARRAY_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_CALC = 3'd1, S_MUL1 = 3'd2,
        S_MUL2 = 3'd3, S_MUL3 = 3'd4, S_DONE = 3'd5
    } state_t;

    typedef struct packed {
        logic [15:0] x_rows, x_cols, w_rows, w_cols, tot_stores;
        logic [7:0]  x_rows_lo, x_cols_lo, w_rows_lo, w_cols_lo;
        logic [31:0] w_tot_len, tot_x_read, z_tot_len;
        logic        ovf;
    } res_t;

    state_t      r_state;
    res_t        r_res;
    logic [3:0]  r_cnt;
    logic [15:0] r_m, r_n, r_k;
    logic        r_mx;
    logic [47:0] r_acc, r_mcand;
    logic [15:0] r_mplier;
    logic [31:0] r_p1;
    logic        r_valid, r_busy;

    logic [15:0] w_x_rows, w_x_cols, w_w_rows, w_w_cols;
    logic [15:0] w_m_mod, w_n_mod_t, w_n_mod_h, w_k_mod;
    logic [47:0] w_sum;
    logic [31:0] w_z_base, w_z;
    logic        w_mx_in;

    always_comb begin
        w_m_mod   = r_m % c_aw;
        w_n_mod_t = r_n % c_tile;
        w_n_mod_h = r_n % c_ah;
        w_k_mod   = r_k % c_tile;
        w_x_rows  = (r_m / c_aw)   + {15'd0, |w_m_mod};
        w_x_cols  = (r_n / c_tile) + {15'd0, |w_n_mod_t};
        w_w_cols  = (r_k / c_tile) + {15'd0, |w_k_mod};
        // Round N up to the CE column count; wraps to 0 at the 16-bit limit.
        w_w_rows  = r_n + ((|w_n_mod_h) ? (c_ah - w_n_mod_h) : 16'd0);
        w_sum     = r_acc + (r_mplier[0] ? r_mcand : 48'd0);
        w_z_base  = c_aw32 * {16'd0, w_sum[15:0]};
    end

`ifdef REDMULE_TILE_PLANNER_MX_EN
    assign w_mx_in = bus.mx_en_i;
    assign w_z     = r_mx ? (w_z_base << 1) : w_z_base;
`else
    logic w_unused_mx;
    assign w_unused_mx = bus.mx_en_i;
    assign w_mx_in     = 1'b0;
    assign w_z         = w_z_base;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;  r_res <= '0;    r_cnt <= '0;
            r_m <= '0;          r_n <= '0;      r_k <= '0;     r_mx <= 1'b0;
            r_acc <= '0;        r_mcand <= '0;  r_mplier <= '0; r_p1 <= '0;
            r_valid <= 1'b0;    r_busy <= 1'b0;
        end else if (bus.clear_i) begin
            r_state <= S_IDLE;  r_res <= '0;    r_cnt <= '0;
            r_m <= '0;          r_n <= '0;      r_k <= '0;     r_mx <= 1'b0;
            r_acc <= '0;        r_mcand <= '0;  r_mplier <= '0; r_p1 <= '0;
            r_valid <= 1'b0;    r_busy <= 1'b0;
        end else begin
            // One shift-add step per MUL cycle; the last step's sum is w_sum.
            if (r_state == S_MUL1 || r_state == S_MUL2 || r_state == S_MUL3) begin
                r_acc    <= w_sum;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 4'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_m     <= bus.m_size_i;
                        r_n     <= bus.n_size_i;
                        r_k     <= bus.k_size_i;
                        r_mx    <= w_mx_in;
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_res.x_rows    <= w_x_rows;
                    r_res.x_cols    <= w_x_cols;
                    r_res.w_rows    <= w_w_rows;
                    r_res.w_cols    <= w_w_cols;
                    r_res.x_rows_lo <= w_m_mod[7:0];
                    r_res.x_cols_lo <= w_n_mod_t[7:0];
                    r_res.w_rows_lo <= w_n_mod_h[7:0];
                    r_res.w_cols_lo <= w_k_mod[7:0];
                    r_res.ovf       <= 1'b0;
                    r_acc           <= '0;
                    r_mcand         <= {32'd0, w_w_cols};
                    r_mplier        <= w_x_rows;
                    r_cnt           <= '0;
                    r_state         <= S_MUL1;
                end
                S_MUL1: begin
                    if (r_cnt == 4'd15) begin
                        r_p1             <= w_sum[31:0];
                        r_res.tot_stores <= w_sum[15:0];
                        r_res.z_tot_len  <= w_z;
                        r_res.ovf        <= |w_sum[47:16];
                        r_acc            <= '0;
                        r_mcand          <= {16'd0, w_sum[31:0]};
                        r_mplier         <= r_res.x_cols;
                        r_state          <= S_MUL2;
                    end
                end
                S_MUL2: begin
                    if (r_cnt == 4'd15) begin
                        r_res.tot_x_read <= w_sum[31:0];
                        r_res.ovf        <= r_res.ovf | (|w_sum[47:32]);
                        r_acc            <= '0;
                        r_mcand          <= {16'd0, r_p1};
                        r_mplier         <= r_res.w_rows;
                        r_state          <= S_MUL3;
                    end
                end
                S_MUL3: begin
                    if (r_cnt == 4'd15) begin
                        r_res.w_tot_len <= w_sum[31:0];
                        r_res.ovf       <= r_res.ovf | (|w_sum[47:32]);
                        r_valid         <= 1'b1;
                        r_state         <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.ready_i) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy_o          = r_busy;
    assign bus.valid_o         = r_valid;
    assign bus.ovf_o           = r_res.ovf;
    assign bus.x_rows_iter_o   = r_res.x_rows;
    assign bus.x_cols_iter_o   = r_res.x_cols;
    assign bus.w_rows_iter_o   = r_res.w_rows;
    assign bus.w_cols_iter_o   = r_res.w_cols;
    assign bus.tot_stores_o    = r_res.tot_stores;
    assign bus.x_rows_lftovr_o = r_res.x_rows_lo;
    assign bus.x_cols_lftovr_o = r_res.x_cols_lo;
    assign bus.w_rows_lftovr_o = r_res.w_rows_lo;
    assign bus.w_cols_lftovr_o = r_res.w_cols_lo;
    assign bus.w_tot_len_o     = r_res.w_tot_len;
    assign bus.tot_x_read_o    = r_res.tot_x_read;
    assign bus.z_tot_len_o     = r_res.z_tot_len;
endmodule
`default_nettype wire

// File: tb/tb_redmule_tile_planner.sv
`default_nettype none
// ============================================================================
// Module      : tb_redmule_tile_planner
// Description : Directed self-checking bench for redmule_tile_planner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_redmule_tile_planner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    redmule_tile_planner_if bus ();

    redmule_tile_planner #(
        .ARRAY_WIDTH (12),
        .ARRAY_HEIGHT(4),
        .PIPE_REGS   (3)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives start during cycle T; returns in cycle T+1.
    task automatic start_op(input logic [15:0] m, input logic [15:0] n,
                            input logic [15:0] k, input logic mx);
        bus.m_size_i = m; bus.n_size_i = n; bus.k_size_i = k; bus.mx_en_i = mx;
        bus.start_i  = 1'b1;
        cycles(1);
        bus.start_i  = 1'b0;
    endtask

    task automatic ack();
        bus.ready_i = 1'b1;
        cycles(1);
        bus.ready_i = 1'b0;
    endtask

    task automatic test_reset();
        bus.clear_i = 0; bus.start_i = 0; bus.ready_i = 0; bus.mx_en_i = 0;
        bus.m_size_i = 0; bus.n_size_i = 0; bus.k_size_i = 0;
        #3;
        n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL rst_busy got %0b want 0", bus.busy_o); else n_pass++;
        n_checks++; if (bus.valid_o !== 1'b0) $display("FAIL rst_valid got %0b want 0", bus.valid_o); else n_pass++;
        n_checks++; if (bus.z_tot_len_o !== 32'd0) $display("FAIL rst_z got %0d want 0", bus.z_tot_len_o); else n_pass++;
        n_checks++; if (bus.x_rows_iter_o !== 16'd0) $display("FAIL rst_xrows got %0d want 0", bus.x_rows_iter_o); else n_pass++;
        cycles(2);
        rst = 1'b0;
        cycles(1);
    endtask

    task automatic test_default();
        start_op(16'd24, 16'd32, 16'd32, 1'b0);
        cycles(48);
        n_checks++; if (bus.valid_o !== 1'b0) $display("FAIL dflt_valid_t49 got %0b want 0", bus.valid_o); else n_pass++;
        n_checks++; if (bus.busy_o !== 1'b1) $display("FAIL dflt_busy got %0b want 1", bus.busy_o); else n_pass++;
        cycles(1);
        n_checks++; if (bus.valid_o !== 1'b1) $display("FAIL dflt_valid_t50 got %0b want 1", bus.valid_o); else n_pass++;
        n_checks++; if (bus.x_rows_iter_o !== 16'd2) $display("FAIL dflt_xrows got %0d want 2", bus.x_rows_iter_o); else n_pass++;
        n_checks++; if (bus.x_cols_iter_o !== 16'd2) $display("FAIL dflt_xcols got %0d want 2", bus.x_cols_iter_o); else n_pass++;
        n_checks++; if (bus.w_cols_iter_o !== 16'd2) $display("FAIL dflt_wcols got %0d want 2", bus.w_cols_iter_o); else n_pass++;
        n_checks++; if (bus.w_rows_iter_o !== 16'd32) $display("FAIL dflt_wrows got %0d want 32", bus.w_rows_iter_o); else n_pass++;
        n_checks++; if (bus.tot_stores_o !== 16'd4) $display("FAIL dflt_stores got %0d want 4", bus.tot_stores_o); else n_pass++;
        n_checks++; if (bus.tot_x_read_o !== 32'd8) $display("FAIL dflt_xread got %0d want 8", bus.tot_x_read_o); else n_pass++;
        n_checks++; if (bus.w_tot_len_o !== 32'd128) $display("FAIL dflt_wlen got %0d want 128", bus.w_tot_len_o); else n_pass++;
        n_checks++; if (bus.z_tot_len_o !== 32'd48) $display("FAIL dflt_zlen got %0d want 48", bus.z_tot_len_o); else n_pass++;
        n_checks++; if ({bus.x_rows_lftovr_o, bus.x_cols_lftovr_o, bus.w_rows_lftovr_o, bus.w_cols_lftovr_o} !== 32'd0)
            $display("FAIL dflt_lftovr got %h want 0", {bus.x_rows_lftovr_o, bus.x_cols_lftovr_o, bus.w_rows_lftovr_o, bus.w_cols_lftovr_o}); else n_pass++;
        n_checks++; if (bus.ovf_o !== 1'b0) $display("FAIL dflt_ovf got %0b want 0", bus.ovf_o); else n_pass++;
        ack();
        n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL dflt_idle_busy got %0b want 0", bus.busy_o); else n_pass++;
        n_checks++; if (bus.w_tot_len_o !== 32'd128) $display("FAIL dflt_idle_hold got %0d want 128", bus.w_tot_len_o); else n_pass++;
    endtask

    task automatic test_leftover();
        start_op(16'd13, 16'd17, 16'd20, 1'b0);
        cycles(49);
        n_checks++; if (bus.valid_o !== 1'b1) $display("FAIL lo_valid got %0b want 1", bus.valid_o); else n_pass++;
        n_checks++; if (bus.x_rows_lftovr_o !== 8'd1) $display("FAIL lo_xrows got %0d want 1", bus.x_rows_lftovr_o); else n_pass++;
        n_checks++; if (bus.x_cols_lftovr_o !== 8'd1) $display("FAIL lo_xcols got %0d want 1", bus.x_cols_lftovr_o); else n_pass++;
        n_checks++; if (bus.w_rows_lftovr_o !== 8'd1) $display("FAIL lo_wrows got %0d want 1", bus.w_rows_lftovr_o); else n_pass++;
        n_checks++; if (bus.w_cols_lftovr_o !== 8'd4) $display("FAIL lo_wcols got %0d want 4", bus.w_cols_lftovr_o); else n_pass++;
        n_checks++; if (bus.w_rows_iter_o !== 16'd20) $display("FAIL lo_wrows_iter got %0d want 20", bus.w_rows_iter_o); else n_pass++;
        n_checks++; if (bus.tot_x_read_o !== 32'd8) $display("FAIL lo_xread got %0d want 8", bus.tot_x_read_o); else n_pass++;
        n_checks++; if (bus.w_tot_len_o !== 32'd80) $display("FAIL lo_wlen got %0d want 80", bus.w_tot_len_o); else n_pass++;
        ack();
    endtask

    task automatic test_mx();
        logic [31:0] exp_z;
`ifdef REDMULE_TILE_PLANNER_MX_EN
        exp_z = 32'd96;
`else
        exp_z = 32'd48;
`endif
        start_op(16'd24, 16'd32, 16'd32, 1'b1);
        cycles(49);
        n_checks++; if (bus.valid_o !== 1'b1) $display("FAIL mx_valid got %0b want 1", bus.valid_o); else n_pass++;
        n_checks++; if (bus.z_tot_len_o !== exp_z) $display("FAIL mx_zlen got %0d want %0d", bus.z_tot_len_o, exp_z); else n_pass++;
        ack();
    endtask

    task automatic test_zero();
        start_op(16'd0, 16'd32, 16'd32, 1'b0);
        cycles(48);
        n_checks++; if (bus.valid_o !== 1'b0) $display("FAIL zero_valid_t49 got %0b want 0", bus.valid_o); else n_pass++;
        cycles(1);
        n_checks++; if (bus.valid_o !== 1'b1) $display("FAIL zero_valid got %0b want 1", bus.valid_o); else n_pass++;
        n_checks++; if (bus.x_rows_iter_o !== 16'd0) $display("FAIL zero_xrows got %0d want 0", bus.x_rows_iter_o); else n_pass++;
        n_checks++; if (bus.tot_stores_o !== 16'd0) $display("FAIL zero_stores got %0d want 0", bus.tot_stores_o); else n_pass++;
        n_checks++; if (bus.tot_x_read_o !== 32'd0) $display("FAIL zero_xread got %0d want 0", bus.tot_x_read_o); else n_pass++;
        n_checks++; if (bus.w_tot_len_o !== 32'd0) $display("FAIL zero_wlen got %0d want 0", bus.w_tot_len_o); else n_pass++;
        n_checks++; if (bus.z_tot_len_o !== 32'd0) $display("FAIL zero_zlen got %0d want 0", bus.z_tot_len_o); else n_pass++;
        n_checks++; if (bus.x_cols_iter_o !== 16'd2) $display("FAIL zero_xcols got %0d want 2", bus.x_cols_iter_o); else n_pass++;
        ack();
    endtask

    task automatic test_ovf();
        start_op(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
        cycles(48);
        n_checks++; if (bus.valid_o !== 1'b0) $display("FAIL ovf_valid_t49 got %0b want 0", bus.valid_o); else n_pass++;
        cycles(1);
        n_checks++; if (bus.valid_o !== 1'b1) $display("FAIL ovf_valid got %0b want 1", bus.valid_o); else n_pass++;
        n_checks++; if (bus.ovf_o !== 1'b1) $display("FAIL ovf_flag got %0b want 1", bus.ovf_o); else n_pass++;
        n_checks++; if (bus.x_rows_iter_o !== 16'd5462) $display("FAIL ovf_xrows got %0d want 5462", bus.x_rows_iter_o); else n_pass++;
        n_checks++; if (bus.tot_stores_o !== 16'h6000) $display("FAIL ovf_stores got %h want 6000", bus.tot_stores_o); else n_pass++;
        n_checks++; if (bus.tot_x_read_o !== 32'h5600_0000) $display("FAIL ovf_xread got %h want 56000000", bus.tot_x_read_o); else n_pass++;
        n_checks++; if (bus.x_rows_lftovr_o !== 8'd3) $display("FAIL ovf_xrows_lo got %0d want 3", bus.x_rows_lftovr_o); else n_pass++;
        ack();
    endtask

    task automatic test_hold();
        start_op(16'd24, 16'd32, 16'd32, 1'b0);
        cycles(49);
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (bus.valid_o !== 1'b1) $display("FAIL hold_valid[%0d] got %0b want 1", i, bus.valid_o); else n_pass++;
            n_checks++; if (bus.tot_x_read_o !== 32'd8 || bus.w_rows_iter_o !== 16'd32)
                $display("FAIL hold_stable[%0d] got %0d/%0d want 8/32", i, bus.tot_x_read_o, bus.w_rows_iter_o); else n_pass++;
            if (i == 3) begin
                bus.m_size_i = 16'd13; bus.n_size_i = 16'd17; bus.start_i = 1'b1;
            end else begin
                bus.start_i = 1'b0;
            end
            cycles(1);
        end
        bus.start_i = 1'b1; bus.ready_i = 1'b1;
        cycles(1);
        bus.start_i = 1'b0; bus.ready_i = 1'b0;
        n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL hold_ack_busy got %0b want 0", bus.busy_o); else n_pass++;
        n_checks++; if (bus.valid_o !== 1'b0) $display("FAIL hold_ack_valid got %0b want 0", bus.valid_o); else n_pass++;
        cycles(1);
        n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL hold_no_start got %0b want 0", bus.busy_o); else n_pass++;
        n_checks++; if (bus.tot_x_read_o !== 32'd8) $display("FAIL hold_idle_keep got %0d want 8", bus.tot_x_read_o); else n_pass++;
    endtask

    task automatic test_clear();
        logic seen;
        start_op(16'd24, 16'd32, 16'd32, 1'b0);
        cycles(19);
        n_checks++; if (bus.busy_o !== 1'b1) $display("FAIL clr_busy_t20 got %0b want 1", bus.busy_o); else n_pass++;
        bus.clear_i = 1'b1; bus.ready_i = 1'b1;
        cycles(1);
        bus.clear_i = 1'b0; bus.ready_i = 1'b0;
        n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL clr_busy_t21 got %0b want 0", bus.busy_o); else n_pass++;
        n_checks++; if (bus.x_rows_iter_o !== 16'd0) $display("FAIL clr_xrows got %0d want 0", bus.x_rows_iter_o); else n_pass++;
        n_checks++; if (bus.tot_x_read_o !== 32'd0) $display("FAIL clr_xread got %0d want 0", bus.tot_x_read_o); else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycles(1);
            if (bus.valid_o === 1'b1) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL clr_no_valid got %0b want 0", seen); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic seen;
        start_op(16'd24, 16'd32, 16'd32, 1'b0);
        cycles(24);
        n_checks++; if (bus.busy_o !== 1'b1) $display("FAIL rmid_busy_pre got %0b want 1", bus.busy_o); else n_pass++;
        rst = 1'b1;
        #2;
        n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL rmid_busy got %0b want 0", bus.busy_o); else n_pass++;
        n_checks++; if (bus.x_rows_iter_o !== 16'd0) $display("FAIL rmid_xrows got %0d want 0", bus.x_rows_iter_o); else n_pass++;
        cycles(2);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cycles(1);
            if (bus.valid_o === 1'b1 || bus.busy_o === 1'b1) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL rmid_no_valid got %0b want 0", seen); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_default();
        test_leftover();
        test_mx();
        test_zero();
        test_ovf();
        test_hold();
        test_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
